// File: rtl/clk_divider_param_if.sv
// Control and status bundle for clk_divider_param: settings and enable in,
// divided clock, strobe and phase/status out.
interface clk_divider_param_if #(
   parameter int unsigned DIV_W = 8
);
   logic             en;
   logic             load;
   logic [DIV_W-1:0] div_in;
   logic             mode_in;
   logic             clkout;
   logic             tick;
   logic [DIV_W-1:0] counter;
   logic [DIV_W-1:0] active_div;
   logic             pending;

   modport master (
      output en, load, div_in, mode_in,
      input  clkout, tick, counter, active_div, pending
   );

   modport slave (
      input  en, load, div_in, mode_in,
      output clkout, tick, counter, active_div, pending
   );
endinterface

// File: rtl/clk_divider_param.sv
// Runtime-programmable integer clock divider with square or pulse output.
// New settings are double-buffered and swapped in only at a period wrap.
module clk_divider_param #(
   parameter int unsigned DIV_W        = 8,
   parameter int unsigned DEFAULT_DIV  = 4,
   parameter bit          DEFAULT_MODE = 1'b0
) (
   input logic                clkin,
   input logic                reset,
   clk_divider_param_if.slave bus
);

   localparam logic [DIV_W-1:0] ResetDiv =
      (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] pdiv_q, pdiv_d;
   logic             mode_q, mode_d;
   logic             pmode_q, pmode_d;
   logic             pend_q, pend_d;
   logic             clkout_q, clkout_d;
   logic             tick_q, tick_d;

   logic [DIV_W-1:0] cap_div;
   logic [DIV_W:0]   high_len;
   logic             wrap;

   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      pdiv_d   = pdiv_q;
      mode_d   = mode_q;
      pmode_d  = pmode_q;
      pend_d   = pend_q;
      clkout_d = clkout_q;
      tick_d   = 1'b0;

      cap_div = (bus.div_in < DIV_W'(2)) ? DIV_W'(2) : bus.div_in;
      wrap    = bus.en && (cnt_q == div_q - DIV_W'(1));

      if (bus.load) begin
         pdiv_d  = cap_div;
         pmode_d = bus.mode_in;
         pend_d  = 1'b1;
      end

      // A load coinciding with the wrap bypasses the pending stage.
      if (wrap) begin
         if (bus.load) begin
            div_d  = cap_div;
            mode_d = bus.mode_in;
            pend_d = 1'b0;
         end else if (pend_q) begin
            div_d  = pdiv_q;
            mode_d = pmode_q;
            pend_d = 1'b0;
         end
      end

      // ceil(D/2) computed one bit wider so D = 2^DIV_W-1 cannot overflow.
      high_len = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;

      if (bus.en) begin
         cnt_d    = wrap ? '0 : cnt_q + DIV_W'(1);
         tick_d   = wrap;
         clkout_d = mode_d ? (cnt_d == '0) : ({1'b0, cnt_d} < high_len);
      end
   end

   always_ff @(posedge clkin) begin
      if (!reset) begin
         cnt_q    <= '0;
         div_q    <= ResetDiv;
         pdiv_q   <= '0;
         mode_q   <= DEFAULT_MODE;
         pmode_q  <= 1'b0;
         pend_q   <= 1'b0;
         clkout_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         pdiv_q   <= pdiv_d;
         mode_q   <= mode_d;
         pmode_q  <= pmode_d;
         pend_q   <= pend_d;
         clkout_q <= clkout_d;
         tick_q   <= tick_d;
      end
   end

   assign bus.clkout     = clkout_q;
   assign bus.tick       = tick_q;
   assign bus.counter    = cnt_q;
   assign bus.active_div = div_q;
   assign bus.pending    = pend_q;

endmodule

// File: tb/tb_clk_divider_param.sv
// Scoreboard bench for clk_divider_param: a behavioural model predicts each
// cycle's outputs at drive time; results are popped and compared after the edge.
module tb_clk_divider_param;

   localparam int DivW = 8;
   localparam int DefDiv = 4;

   typedef struct {
      int cnt;
      int ck;
      int tk;
      int div;
      int pend;
   } exp_t;

   logic clkin = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;
   exp_t sb_q[$];

   // model state
   int m_cnt, m_div, m_mode, m_pend, m_pdiv, m_pmode, m_ck, m_tk;

   clk_divider_param_if #(.DIV_W(DivW)) bus ();

   clk_divider_param #(
      .DIV_W        (DivW),
      .DEFAULT_DIV  (DefDiv),
      .DEFAULT_MODE (1'b0)
   ) dut (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clkin = ~clkin;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model(input int rst, input int en, input int ld, input int di, input int mi);
      int cap;
      int wrap;
      if (rst == 0) begin
         m_cnt = 0; m_ck = 0; m_tk = 0; m_pend = 0; m_pdiv = 0; m_pmode = 0;
         m_div = (DefDiv < 2) ? 2 : DefDiv;
         m_mode = 0;
         return;
      end
      cap = (di < 2) ? 2 : di;
      wrap = (en != 0) && (m_cnt == m_div - 1);
      if (wrap) begin
         if (ld != 0) begin
            m_div = cap; m_mode = mi; m_pend = 0;
         end else if (m_pend != 0) begin
            m_div = m_pdiv; m_mode = m_pmode; m_pend = 0;
         end
      end
      if (ld != 0) begin
         m_pdiv = cap; m_pmode = mi;
         if (!wrap) m_pend = 1;
      end
      m_tk = wrap;
      if (en != 0) begin
         m_cnt = wrap ? 0 : m_cnt + 1;
         if (m_mode != 0) m_ck = (m_cnt == 0);
         else             m_ck = (m_cnt < (m_div + 1) / 2);
      end
   endtask

   task automatic step(input int rst, input int en, input int ld, input int di, input int mi);
      exp_t e;
      exp_t g;
      @(negedge clkin);
      reset       = rst[0];
      bus.en      = en[0];
      bus.load    = ld[0];
      bus.div_in  = di[DivW-1:0];
      bus.mode_in = mi[0];
      model(rst, en, ld, di, mi);
      e.cnt = m_cnt; e.ck = m_ck; e.tk = m_tk; e.div = m_div; e.pend = m_pend;
      sb_q.push_back(e);
      @(posedge clkin);
      #1;
      g = sb_q.pop_front();
      check_eq("counter", int'(bus.counter), g.cnt);
      check_eq("clkout", int'(bus.clkout), g.ck);
      check_eq("tick", int'(bus.tick), g.tk);
      check_eq("active_div", int'(bus.active_div), g.div);
      check_eq("pending", int'(bus.pending), g.pend);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
   endtask

   // Advance with en=1 until the model counter reaches target (bounded).
   task automatic run_to(input int target);
      for (int g = 0; g < 300 && m_cnt != target; g++) step(1, 1, 0, 0, 0);
   endtask

   initial begin
      bus.en = 1'b0; bus.load = 1'b0; bus.div_in = '0; bus.mode_in = 1'b0;
      m_cnt = 0; m_div = DefDiv; m_mode = 0; m_pend = 0;
      m_pdiv = 0; m_pmode = 0; m_ck = 0; m_tk = 0;

      // reset, with load and en asserted to show reset wins
      step(0, 1, 1, 9, 1);
      step(0, 0, 0, 0, 0);
      run(10);

      // load D=5 at counter 1, swap at the next wrap
      run_to(1);
      step(1, 1, 1, 5, 0);
      run(12);
      check_eq("active_div_5", int'(bus.active_div), 5);

      // load D=3 pulse on the wrap cycle: bypass
      run_to(4);
      step(1, 1, 1, 3, 1);
      check_eq("bypass_cnt", int'(bus.counter), 0);
      check_eq("bypass_div", int'(bus.active_div), 3);
      check_eq("bypass_pend", int'(bus.pending), 0);
      run(9);

      // two loads, last (0 -> clamp 2) wins
      run_to(0);
      step(1, 1, 1, 6, 0);
      step(1, 1, 1, 0, 0);
      run(6);
      check_eq("clamp_div", int'(bus.active_div), 2);

      // en=0 hold at counter 2
      step(1, 1, 1, 4, 0);
      run(4);
      run_to(2);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check_eq("resume_cnt", int'(bus.counter), 3);

      // load while disabled, then reset while pending at counter 3
      run_to(1);
      step(1, 0, 1, 7, 1);
      run_to(3);
      check_eq("pend_before_rst", int'(bus.pending), 1);
      step(0, 1, 0, 0, 0);
      check_eq("rst_div", int'(bus.active_div), DefDiv);
      run(8);

      // random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 60) == 0) ? 0 : 1,
              ($urandom_range(0, 4) != 0) ? 1 : 0,
              ($urandom_range(0, 9) == 0) ? 1 : 0,
              int'($urandom_range(0, 12)),
              int'($urandom_range(0, 1)));
      end

      // large divisor: exercises ceil(D/2) at the top of the range
      step(1, 1, 1, 255, 0);
      run(520);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
